// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-datapath FSM states and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when a borrow is needed.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing A - B - Bin over WIDTH cycles with a
// start/busy/done handshake; one full-subtractor stage is reused every cycle.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             ovf
);

  localparam int unsigned      SUB_CNT_W = cnt_width(WIDTH);
  localparam logic [SUB_CNT_W-1:0] CNT_LAST  = SUB_CNT_W'(WIDTH - 1);

  state_t state, state_next;
  logic   load_c, shift_c, last_c;

  logic [WIDTH-1:0]     a_sr, b_sr;
  logic [WIDTH-1:1]     res_sr;
  logic [WIDTH:1]       res_cat_c;
  logic                 brw, a_msb, b_msb;
  logic [SUB_CNT_W-1:0] cnt;
  logic                 d_c, brw_c;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .diff (d_c),
    .bout (brw_c)
  );

  // New difference bit enters at the top; the first bit computed lands in Diff[0].
  assign res_cat_c = {d_c, res_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    shift_c    = 1'b0;
    last_c     = (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (last_c) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
    end else if (load_c) begin
      a_sr   <= A;
      b_sr   <= B;
      res_sr <= '0;
      brw    <= Bin;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
      cnt    <= '0;
    end else if (shift_c) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_cat_c[WIDTH:2];
      brw    <= brw_c;
      cnt    <= cnt + SUB_CNT_W'(1);
    end
  end

  // Result ports update only on the final shift and hold until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff <= '0;
      Bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (shift_c && last_c) begin
      Diff <= res_cat_c;
      Bout <= brw_c;
      ovf  <= (a_msb != b_msb) && (d_c != a_msb);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done, bout, ovf;
  logic [WIDTH-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .busy  (busy),
    .done  (done),
    .Diff  (diff),
    .Bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; returns negedges from acceptance to done and busy cycles seen.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic op_bin, output int lat, output int busy_cyc);
    @(negedge clk);
    a = op_a; b = op_b; bin = op_bin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    lat = 1; busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] op_a,
                          input logic [WIDTH-1:0] op_b, input logic op_bin,
                          input logic [WIDTH-1:0] exp_d, input logic exp_bo, input logic exp_ov);
    int lat, bc;
    run_op(op_a, op_b, op_bin, lat, bc);
    check({name, "_latency"}, 32'(lat), 32'(WIDTH + 1));
    check({name, "_busy_cycles"}, 32'(bc), 32'(WIDTH));
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    check({name, "_diff"}, 32'(diff), 32'(exp_d));
    check({name, "_bout"}, 32'(bout), 32'(exp_bo));
    check({name, "_ovf"}, 32'(ovf), 32'(exp_ov));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bc, ndone, first_t, second_t;
    logic [WIDTH-1:0] d_seen, d1, d2;
    logic [4:0] ref_t;
    logic ref_ov;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("op_5m3",   4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_hold_diff", 32'(diff), 32'h2);
    directed("op_3m5",   4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0);
    directed("op_0m0b1", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
    directed("op_8m1",   4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
    directed("op_7m15",  4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1);

    // start pulse while shifting must be ignored
    @(negedge clk);
    a = 4'b0110; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b1111; b = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; d_seen = '0;
    for (int t = 0; t < 15; t++) begin
      if (done) begin ndone++; d_seen = diff; end
      @(negedge clk);
    end
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_diff", 32'(d_seen), 32'h5);
    check("ignore_busy_idle", 32'(busy), 32'd0);

    // back-to-back: start held through DONE
    @(negedge clk);
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'b1111; b = 4'b0001;
    first_t = -1; second_t = -1; d1 = '0; d2 = '0;
    for (int t = 1; t <= 20; t++) begin
      if (done) begin
        if (first_t < 0) begin first_t = t; d1 = diff; end
        else if (second_t < 0) begin second_t = t; d2 = diff; end
      end
      if (first_t > 0 && t == first_t + 1) begin
        check("b2b_busy_no_gap", 32'(busy), 32'd1);
        start = 1'b0; a = '0; b = '0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_first_done_t", 32'(first_t), 32'(WIDTH + 1));
    check("b2b_spacing", 32'(second_t - first_t), 32'(WIDTH + 1));
    check("b2b_diff1", 32'(d1), 32'h2);
    check("b2b_diff2", 32'(d2), 32'he);

    // asynchronous reset in the middle of SHIFT
    directed("pre_rst", 4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1);
    @(negedge clk);
    a = 4'b1001; b = 4'b0010; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    check("arst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("arst_no_done", 32'(ndone), 32'd0);

    // exhaustive sweep against a reference subtraction
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          ref_t  = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
          ref_ov = (4'(ai) >> 3) != (4'(bi) >> 3) && ref_t[3] != 1'((ai >> 3) & 1);
          run_op(4'(ai), 4'(bi), 1'(ci), lat, bc);
          check($sformatf("sweep_diff_%0h_%0h_%0d", ai, bi, ci), 32'(diff), 32'(ref_t[3:0]));
          check($sformatf("sweep_bout_%0h_%0h_%0d", ai, bi, ci), 32'(bout), 32'(ref_t[4]));
          check($sformatf("sweep_ovf_%0h_%0h_%0d", ai, bi, ci), 32'(ovf), 32'(ref_ov));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
